seg7_bcd_timer: RTL and testbench



---
 rtl/seg7_bcd_timer_if.sv | 26 ++
 rtl/seg7_bcd_timer.sv | 156 +++++++++++++++
 tb/tb_seg7_bcd_timer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_bcd_timer_if.sv
// Bus bundle for seg7_bcd_timer: control/preset inputs and display outputs.
//   master: drives en, mode_down, load, load_val; observes bcd, seg, dp, digit_sel, wrap
//   slave : the timer side (inverse directions)
interface seg7_bcd_timer_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  en;
  logic                  mode_down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     digit_sel;
  logic                  wrap;

  modport master (
    output en, mode_down, load, load_val,
    input  bcd, seg, dp, digit_sel, wrap
  );

  modport slave (
    input  en, mode_down, load, load_val,
    output bcd, seg, dp, digit_sel, wrap
  );
endinterface

// File: rtl/seg7_bcd_timer.sv
// Multi-digit BCD seconds timer with a multiplexed 7-segment display driver.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave modport) en/mode_down/load/load_val in; bcd/seg/dp/digit_sel/wrap out
// A prescaler produces a count tick every TICK_DIV enabled cycles; on a tick the
// BCD value steps up or down with carry/borrow across digits. A free-running scan
// counter rotates one digit onto seg every SCAN_DIV cycles.
module seg7_bcd_timer #(
  parameter int unsigned TICK_DIV = 10000000,
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCAN_DIV = 10000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_bcd_timer_if.slave      bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BW = 4 * DIGITS;

  logic [PW-1:0]     pre_q,  pre_d;
  logic [BW-1:0]     bcd_q,  bcd_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q,  idx_d;
  logic              wrap_q, wrap_d;

  logic              tick_c;
  logic [BW-1:0]     cnt_c;
  logic              roll_c;
  logic [BW-1:0]     ld_c;
  logic [3:0]        nib_c;
  logic [DIGITS-1:0] sel_c;
  logic [6:0]        seg_c;
  logic              dp_c;

  // Ripple increment/decrement across digits; roll_c survives only if every digit rolled.
  always_comb begin
    tick_c = bus.en && (pre_q == PW'(TICK_DIV - 1));
    cnt_c  = bcd_q;
    roll_c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (roll_c) begin
        if (!bus.mode_down) begin
          if (bcd_q[4*i +: 4] >= 4'd9) begin
            cnt_c[4*i +: 4] = 4'd0;
          end else begin
            cnt_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            roll_c          = 1'b0;
          end
        end else begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            cnt_c[4*i +: 4] = 4'd9;
          end else begin
            cnt_c[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            roll_c          = 1'b0;
          end
        end
      end
    end
  end

  // Preset value with out-of-range nibbles clamped to 9.
  always_comb begin
    ld_c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ld_c[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*i +: 4];
    end
  end

  // Next state: load beats tick; en gates the prescaler and count, never the scan.
  always_comb begin
    pre_d  = pre_q;
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;

    if (bus.load) begin
      pre_d = '0;
      bcd_d = ld_c;
    end else if (bus.en) begin
      if (tick_c) begin
        pre_d  = '0;
        bcd_d  = cnt_c;
        wrap_d = roll_c;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      bcd_q  <= '0;
      scan_q <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      bcd_q  <= bcd_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  // Select the scanned digit and its one-hot enable.
  always_comb begin
    nib_c = 4'd0;
    sel_c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib_c    = bcd_q[4*i +: 4];
        sel_c[i] = 1'b1;
      end
    end
  end

  // Segment decode, bit0 = a.
  always_comb begin
    seg_c = 7'h00;
    case (nib_c)
      4'd0:    seg_c = 7'h3F;
      4'd1:    seg_c = 7'h06;
      4'd2:    seg_c = 7'h5B;
      4'd3:    seg_c = 7'h4F;
      4'd4:    seg_c = 7'h66;
      4'd5:    seg_c = 7'h6D;
      4'd6:    seg_c = 7'h7D;
      4'd7:    seg_c = 7'h07;
      4'd8:    seg_c = 7'h7F;
      4'd9:    seg_c = 7'h6F;
      default: seg_c = 7'h00;
    endcase
  end

  // Units-digit decimal point blinks during the first half of each tick period.
  always_comb begin
    dp_c = (idx_q == '0) && (pre_q < PW'(TICK_DIV / 2));
  end

  assign bus.bcd       = bcd_q;
  assign bus.seg       = seg_c;
  assign bus.dp        = dp_c;
  assign bus.digit_sel = sel_c;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_seg7_bcd_timer.sv
// Self-checking bench for seg7_bcd_timer (TICK_DIV=4, DIGITS=2, SCAN_DIV=2).
// Every step is compared against an arithmetic reference model (count kept as an
// integer, scan position derived from elapsed cycles), plus table vectors and
// hand-derived corner sequences.
module tb_seg7_bcd_timer;

  localparam int TICK_DIV = 4;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 2;
  localparam int BW       = 4 * DIGITS;
  localparam int MODV     = 10 ** DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg7_bcd_timer_if #(.DIGITS(DIGITS)) bus ();

  seg7_bcd_timer #(
    .TICK_DIV (TICK_DIV),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ld;
    logic [BW-1:0] lv;
    logic          en;
    logic          dn;
    logic [BW-1:0] bcd;
    logic          wrap;
  } vec_t;

  vec_t tbl[$];

  logic [6:0] seg_lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_pre;
  int m_val;
  int m_cyc;
  bit m_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pw10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pw10(i)) % 10);
    return r;
  endfunction

  function automatic int clamp_val(input logic [BW-1:0] lv);
    int v = 0;
    int n;
    for (int i = 0; i < DIGITS; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * pw10(i);
    end
    return v;
  endfunction

  task automatic model_reset();
    m_pre  = 0;
    m_val  = 0;
    m_cyc  = 0;
    m_wrap = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    bit tick;
    tick = bus.en && (m_pre == TICK_DIV - 1);
    m_wrap = 1'b0;
    if (bus.load) begin
      m_val = clamp_val(bus.load_val);
      m_pre = 0;
    end else if (bus.en) begin
      m_pre = (m_pre + 1) % TICK_DIV;
      if (tick) begin
        if (!bus.mode_down) begin
          m_wrap = (m_val == MODV - 1);
          m_val  = (m_val + 1) % MODV;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + MODV - 1) % MODV;
        end
      end
    end
    m_cyc++;
  endtask

  task automatic check_model(input string tag);
    int idx;
    int dig;
    idx = (m_cyc / SCAN_DIV) % DIGITS;
    dig = (m_val / pw10(idx)) % 10;
    check({tag, ".bcd"},  32'(bus.bcd),       32'(to_bcd(m_val)));
    check({tag, ".seg"},  32'(bus.seg),       32'(seg_lut[dig]));
    check({tag, ".sel"},  32'(bus.digit_sel), 32'(1) << idx);
    check({tag, ".dp"},   32'(bus.dp),        32'((idx == 0) && (m_pre < TICK_DIV / 2)));
    check({tag, ".wrap"}, 32'(bus.wrap),      32'(m_wrap));
  endtask

  task automatic step(input logic ld, input logic [BW-1:0] lv, input logic en,
                      input logic dn, input string tag);
    bus.load      = ld;
    bus.load_val  = lv;
    bus.en        = en;
    bus.mode_down = dn;
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  function automatic void add(input logic ld, input logic [BW-1:0] lv, input logic en,
                              input logic dn, input logic [BW-1:0] b, input logic w);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = en; v.dn = dn; v.bcd = b; v.wrap = w;
    tbl.push_back(v);
  endfunction

  initial begin
    bus.load      = 1'b0;
    bus.load_val  = '0;
    bus.en        = 1'b0;
    bus.mode_down = 1'b0;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.bcd", 32'(bus.bcd), 32'h00);
    check("rst.sel", 32'(bus.digit_sel), 32'h1);
    check("rst.seg", 32'(bus.seg), 32'h3F);
    check("rst.dp",  32'(bus.dp), 32'h1);
    check("rst.wrap", 32'(bus.wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up from zero: one tick per 4 cycles, 09 -> 10 carry at cycle 40
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, '0, 1'b1, 1'b0, "up40");
      if (k == 39) check("up40.pre_carry", 32'(bus.bcd), 32'h09);
      if (k == 40) check("up40.carry", 32'(bus.bcd), 32'h10);
    end

    // Table: up-wrap from 98, down-wrap from 00, clamp, load with en low
    add(1, 8'h98, 1, 0, 8'h98, 0);
    for (int i = 0; i < 3; i++) add(0, '0, 1, 0, 8'h98, 0);
    for (int i = 0; i < 4; i++) add(0, '0, 1, 0, 8'h99, 0);
    add(0, '0, 1, 0, 8'h00, 1);
    add(0, '0, 1, 0, 8'h00, 0);
    add(1, 8'h00, 1, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, '0, 1, 1, 8'h00, 0);
    add(0, '0, 1, 1, 8'h99, 1);
    add(0, '0, 1, 1, 8'h99, 0);
    add(1, 8'h3F, 1, 1, 8'h39, 0);
    add(1, 8'h42, 0, 0, 8'h42, 0);
    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].ld, tbl[r].lv, tbl[r].en, tbl[r].dn, "tbl");
      check($sformatf("tbl[%0d].bcd", r),  32'(bus.bcd),  32'(tbl[r].bcd));
      check($sformatf("tbl[%0d].wrap", r), 32'(bus.wrap), 32'(tbl[r].wrap));
    end

    // Scan with bcd=42 held, prescaler at 0
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, "scan");
      if (((m_cyc / SCAN_DIV) % DIGITS) == 0) begin
        check("scan.seg_d0", 32'(bus.seg), 32'h5B);
        check("scan.dp_d0",  32'(bus.dp),  32'h1);
      end else begin
        check("scan.seg_d1", 32'(bus.seg), 32'h66);
        check("scan.dp_d1",  32'(bus.dp),  32'h0);
      end
    end

    // Load coincident with a wrapping tick: load wins, no wrap
    step(1'b1, 8'h99, 1'b1, 1'b0, "coll");
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, "coll");
    step(1'b1, 8'h42, 1'b1, 1'b0, "coll");
    check("coll.bcd", 32'(bus.bcd), 32'h42);
    check("coll.wrap", 32'(bus.wrap), 32'h0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, "coll");
    check("coll.hold", 32'(bus.bcd), 32'h42);
    step(1'b0, '0, 1'b1, 1'b0, "coll");
    check("coll.next", 32'(bus.bcd), 32'h43);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, "enlo");
      check("enlo.bcd", 32'(bus.bcd), 32'h43);
    end

    // Direction change between ticks applies at the next tick
    step(1'b1, 8'h50, 1'b1, 1'b0, "dir");
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, "dir");
    repeat (2) step(1'b0, '0, 1'b1, 1'b1, "dir");
    check("dir.bcd", 32'(bus.bcd), 32'h49);

    // Asynchronous reset mid-count at 37
    step(1'b1, 8'h37, 1'b1, 1'b0, "mid");
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, "mid");
    check("mid.pre", 32'(bus.bcd), 32'h37);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.bcd", 32'(bus.bcd), 32'h00);
    check("arst.sel", 32'(bus.digit_sel), 32'h1);
    check("arst.seg", 32'(bus.seg), 32'h3F);
    check("arst.dp",  32'(bus.dp), 32'h1);
    check("arst.wrap", 32'(bus.wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 15) == 0), BW'($urandom), ($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
